// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_pkg
// Description : Shared types and helpers for the byte-lane data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    DM_CLEAR = 1'b0,
    DM_RUN   = 1'b1
  } dmState_t;

  // Bit index of the LSB of byte lane 'lane' in a big-endian word (lane 0 = MSB)
  function automatic int laneLsb(input int dataW, input int lane);
    return dataW - BYTE_W * (lane + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : dm_clear_seq
// Description : Walks every byte address once after reset, producing a
//               zero-write strobe and a done flag on the last byte.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_clear_seq
  import dm_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int IDX_W       = 7
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Enable,
  output logic [IDX_W-1:0] ClearAddr,
  output logic             ClearWrite,
  output logic             ClearDone
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_BYTES - 1);

  logic [IDX_W-1:0] rCount;

  // Byte counter advances once per clearing cycle; restarts from 0 on reset
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      rCount <= '0;
    end else if (Enable) begin
      rCount <= rCount + IDX_W'(1);
    end
  end

  assign ClearAddr  = rCount;
  assign ClearWrite = Enable;
  assign ClearDone  = Enable && (rCount == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/byte_lane_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : byte_lane_data_memory
// Description : Byte-addressed big-endian data memory with per-lane write
//               enables, registered reads, range checking and an optional
//               post-reset clear sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_data_memory
  import dm_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int DEPTH_BYTES    = 128,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     Clock,
  input  logic                     ResetN,
  input  logic [ADDR_W-1:0]        Address,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic [DATA_W/BYTE_W-1:0] ByteEnable,
  input  logic                     MemWrite,
  input  logic                     MemRead,
  output logic [DATA_W-1:0]        ReadData,
  output logic                     ReadValid,
  output logic                     Ready,
  output logic                     AddrError
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam dmState_t RESET_STATE = (CLEAR_ON_RESET != 0) ? DM_CLEAR : DM_RUN;

  logic [BYTE_W-1:0] rMem [DEPTH_BYTES];
  dmState_t          rState;
  dmState_t          wNextState;
  logic [IDX_W-1:0]  wClearAddr;
  logic              wClearWrite;
  logic              wClearDone;
  logic              wClearEnable;
  logic [ADDR_W:0]   wEndAddr;
  logic              wInRange;
  logic              wAccRead;
  logic              wAccWrite;
  logic              wWriteOk;
  logic [IDX_W-1:0]  wLaneIdx [NB];
  logic [DATA_W-1:0] wReadWord;

  assign wClearEnable = (rState == DM_CLEAR);

  generate
    if (CLEAR_ON_RESET != 0) begin : g_clearSeq
      dm_clear_seq #(
        .DEPTH_BYTES(DEPTH_BYTES),
        .IDX_W      (IDX_W)
      ) uClearSeq (
        .Clock     (Clock),
        .ResetN    (ResetN),
        .Enable    (wClearEnable),
        .ClearAddr (wClearAddr),
        .ClearWrite(wClearWrite),
        .ClearDone (wClearDone)
      );
    end else begin : g_noClear
      assign wClearAddr  = '0;
      assign wClearWrite = 1'b0;
      assign wClearDone  = 1'b0;
    end
  endgenerate

  // State register: reset lands in CLEAR or straight in RUN
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      rState <= RESET_STATE;
    end else begin
      rState <= wNextState;
    end
  end

  // Next state and Ready; CLEAR exits after the last byte is zeroed
  always_comb begin
    wNextState = rState;
    Ready      = 1'b0;
    case (rState)
      DM_CLEAR: if (wClearDone) wNextState = DM_RUN;
      DM_RUN:   Ready = 1'b1;
      default:  wNextState = RESET_STATE;
    endcase
  end

  // Range check at ADDR_W+1 bits so the last-byte sum never wraps
  assign wEndAddr  = {1'b0, Address} + (ADDR_W + 1)'(NB - 1);
  assign wInRange  = (wEndAddr < (ADDR_W + 1)'(DEPTH_BYTES));
  assign wAccRead  = Ready && MemRead;
  assign wAccWrite = Ready && MemWrite;
  assign wWriteOk  = wAccWrite && wInRange;

  // Per-lane byte index and big-endian assembly of the addressed word
  always_comb begin
    wReadWord = '0;
    for (int k = 0; k < NB; k++) begin
      wLaneIdx[k] = IDX_W'({1'b0, Address} + (ADDR_W + 1)'(k));
      wReadWord[laneLsb(DATA_W, k) +: BYTE_W] = rMem[wLaneIdx[k]];
    end
  end

  // Storage: clear sequencer has priority, otherwise enabled lanes are written
  always_ff @(posedge Clock) begin
    if (wClearWrite) begin
      rMem[wClearAddr] <= '0;
    end else if (wWriteOk) begin
      for (int k = 0; k < NB; k++) begin
        if (ByteEnable[NB-1-k]) begin
          rMem[wLaneIdx[k]] <= WriteData[laneLsb(DATA_W, k) +: BYTE_W];
        end
      end
    end
  end

  // Read register, valid strobe and range-error strobe
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      ReadData  <= '0;
      ReadValid <= 1'b0;
      AddrError <= 1'b0;
    end else begin
      ReadValid <= wAccRead;
      AddrError <= (wAccRead || wAccWrite) && !wInRange;
      if (wAccRead) begin
        ReadData <= wInRange ? wReadWord : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_byte_lane_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_lane_data_memory
// Description : Directed vector bench for byte_lane_data_memory (16-bit
//               default, 32-bit/256-byte variant, and no-clear variant).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_byte_lane_data_memory;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Default instance
  logic        ResetN;
  logic [15:0] Address, WriteData, ReadData;
  logic [1:0]  ByteEnable;
  logic        MemWrite, MemRead, ReadValid, Ready, AddrError;

  // 32-bit / 256-byte instance
  logic        ResetN32;
  logic [15:0] Address32;
  logic [31:0] WriteData32, ReadData32;
  logic [3:0]  ByteEnable32;
  logic        MemWrite32, MemRead32, ReadValid32, Ready32, AddrError32;

  // No-clear instance (shares ResetN)
  logic [15:0] ncAddress, ncReadData;
  logic        ncRead, ncValid, ncReady, ncErr;

  int nVec = 0;
  int nMis = 0;

  byte_lane_data_memory dut (
    .Clock(Clock), .ResetN(ResetN), .Address(Address), .WriteData(WriteData),
    .ByteEnable(ByteEnable), .MemWrite(MemWrite), .MemRead(MemRead),
    .ReadData(ReadData), .ReadValid(ReadValid), .Ready(Ready), .AddrError(AddrError)
  );

  byte_lane_data_memory #(.DATA_W(32), .DEPTH_BYTES(256)) dut32 (
    .Clock(Clock), .ResetN(ResetN32), .Address(Address32), .WriteData(WriteData32),
    .ByteEnable(ByteEnable32), .MemWrite(MemWrite32), .MemRead(MemRead32),
    .ReadData(ReadData32), .ReadValid(ReadValid32), .Ready(Ready32), .AddrError(AddrError32)
  );

  byte_lane_data_memory #(.CLEAR_ON_RESET(0)) dutNc (
    .Clock(Clock), .ResetN(ResetN), .Address(ncAddress), .WriteData(16'h0000),
    .ByteEnable(2'b00), .MemWrite(1'b0), .MemRead(ncRead),
    .ReadData(ncReadData), .ReadValid(ncValid), .Ready(ncReady), .AddrError(ncErr)
  );

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        wr;
    logic        rd;
    logic [15:0] expData;
    logic        expValid;
    logic        expErr;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts posedges until Ready rises; checks requests are ignored meanwhile
  task automatic waitReady(input bit wide, input int expCycles, input string name);
    int  n;
    bit  leaked;
    n      = 0;
    leaked = 1'b0;
    while (n < 1000) begin
      @(posedge Clock); #1;
      n++;
      if (wide ? (ReadValid32 || AddrError32) : (ReadValid || AddrError)) leaked = 1'b1;
      if (wide ? Ready32 : Ready) break;
    end
    check({name, ".cycles"}, n, expCycles);
    check({name, ".ignored"}, {31'd0, leaked}, 32'd0);
  endtask

  task automatic op16(input string name, input logic [15:0] a, input logic [15:0] d,
                      input logic [1:0] be, input logic wr, input logic rd,
                      input logic [15:0] expData, input logic expValid, input logic expErr);
    Address = a; WriteData = d; ByteEnable = be; MemWrite = wr; MemRead = rd;
    @(posedge Clock); #1;
    MemWrite = 1'b0; MemRead = 1'b0;
    check({name, ".data"},  {16'd0, ReadData}, {16'd0, expData});
    check({name, ".valid"}, {31'd0, ReadValid}, {31'd0, expValid});
    check({name, ".err"},   {31'd0, AddrError}, {31'd0, expErr});
  endtask

  task automatic op32(input string name, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic wr, input logic rd,
                      input logic [31:0] expData, input logic expValid, input logic expErr);
    Address32 = a; WriteData32 = d; ByteEnable32 = be; MemWrite32 = wr; MemRead32 = rd;
    @(posedge Clock); #1;
    MemWrite32 = 1'b0; MemRead32 = 1'b0;
    check({name, ".data"},  ReadData32, expData);
    check({name, ".valid"}, {31'd0, ReadValid32}, {31'd0, expValid});
    check({name, ".err"},   {31'd0, AddrError32}, {31'd0, expErr});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    //            name     addr      wdata     be     wr    rd    expData   vld   err
    vecs[0]  = '{"rd0",    16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{"wr2",    16'h0002, 16'h1234, 2'b11, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{"rd2a",   16'h0002, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0};
    vecs[3]  = '{"rd3",    16'h0003, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h3400, 1'b1, 1'b0};
    vecs[4]  = '{"wrLo",   16'h0002, 16'hABCD, 2'b01, 1'b1, 1'b0, 16'h3400, 1'b0, 1'b0};
    vecs[5]  = '{"rd2b",   16'h0002, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h12CD, 1'b1, 1'b0};
    vecs[6]  = '{"wrHi",   16'h0002, 16'hEF00, 2'b10, 1'b1, 1'b0, 16'h12CD, 1'b0, 1'b0};
    vecs[7]  = '{"rd2c",   16'h0002, 16'h0000, 2'b00, 1'b0, 1'b1, 16'hEFCD, 1'b1, 1'b0};
    vecs[8]  = '{"rdwr",   16'h0002, 16'h5678, 2'b11, 1'b1, 1'b1, 16'hEFCD, 1'b1, 1'b0};
    vecs[9]  = '{"rd2d",   16'h0002, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h5678, 1'b1, 1'b0};
    vecs[10] = '{"wr127",  16'h007F, 16'h1111, 2'b11, 1'b1, 1'b0, 16'h5678, 1'b0, 1'b1};
    vecs[11] = '{"rd126a", 16'h007E, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[12] = '{"rdFFFF", 16'hFFFF, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};
    vecs[13] = '{"wr126",  16'h007E, 16'hAA55, 2'b11, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[14] = '{"rd126b", 16'h007E, 16'h0000, 2'b00, 1'b0, 1'b1, 16'hAA55, 1'b1, 1'b0};
    vecs[15] = '{"idle",   16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 16'hAA55, 1'b0, 1'b0};
    vecs[16] = '{"wrFFFF", 16'hFFFF, 16'h9999, 2'b11, 1'b1, 1'b0, 16'hAA55, 1'b0, 1'b1};

    ResetN = 1'b0; Address = '0; WriteData = '0; ByteEnable = '0; MemWrite = 1'b0; MemRead = 1'b0;
    ResetN32 = 1'b0; Address32 = '0; WriteData32 = '0; ByteEnable32 = '0; MemWrite32 = 1'b0; MemRead32 = 1'b0;
    ncAddress = '0; ncRead = 1'b0;

    repeat (3) @(posedge Clock);
    #1;
    check("rst.data",    {16'd0, ReadData}, 32'd0);
    check("rst.valid",   {31'd0, ReadValid}, 32'd0);
    check("rst.err",     {31'd0, AddrError}, 32'd0);
    check("rst.ready",   {31'd0, Ready}, 32'd0);
    check("nc.rstReady", {31'd0, ncReady}, 32'd1);
    check("nc.rstValid", {31'd0, ncValid}, 32'd0);

    // Requests held active through the clear phase must be ignored
    Address = 16'hFFFF; MemRead = 1'b1; MemWrite = 1'b1; ByteEnable = 2'b11;
    @(negedge Clock);
    ResetN = 1'b1;
    waitReady(1'b0, 128, "clear1");
    MemRead = 1'b0; MemWrite = 1'b0;

    for (int i = 0; i < NV; i++) begin
      op16(vecs[i].name, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].wr, vecs[i].rd,
           vecs[i].expData, vecs[i].expValid, vecs[i].expErr);
    end

    // No-clear instance is live right after reset and range-checks too
    ncAddress = 16'hFFFF; ncRead = 1'b1;
    @(posedge Clock); #1;
    ncRead = 1'b0;
    check("nc.errValid", {30'd0, ncValid, ncErr}, 32'd3);
    check("nc.data",     {16'd0, ncReadData}, 32'd0);

    // Reset while a read strobe is in flight drops it immediately
    op16("preRst", 16'h0002, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h5678, 1'b1, 1'b0);
    ResetN = 1'b0;
    #1;
    check("midRst.valid", {31'd0, ReadValid}, 32'd0);
    check("midRst.data",  {16'd0, ReadData}, 32'd0);
    check("midRst.ready", {31'd0, Ready}, 32'd0);

    // Partial clear interrupted at cycle 50, then a full clear from byte 0
    @(negedge Clock);
    ResetN = 1'b1;
    repeat (50) @(posedge Clock);
    #1;
    ResetN = 1'b0;
    #1;
    check("abort.ready", {31'd0, Ready}, 32'd0);
    @(negedge Clock);
    ResetN = 1'b1;
    waitReady(1'b0, 128, "clear2");
    op16("post.rd2",   16'h0002, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    op16("post.rd126", 16'h007E, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // 32-bit, 256-byte variant
    @(negedge Clock);
    ResetN32 = 1'b1;
    waitReady(1'b1, 256, "clear32");
    op32("w32.wr4",   16'h0004, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    op32("w32.rd4",   16'h0004, 32'h0,        4'b0000, 1'b0, 1'b1, 32'hDEADBEEF,  1'b1, 1'b0);
    op32("w32.rd7",   16'h0007, 32'h0,        4'b0000, 1'b0, 1'b1, 32'hEF000000,  1'b1, 1'b0);
    op32("w32.rd3",   16'h0003, 32'h0,        4'b0000, 1'b0, 1'b1, 32'h00DEADBE,  1'b1, 1'b0);
    op32("w32.wr253", 16'h00FD, 32'h12345678, 4'b1111, 1'b1, 1'b0, 32'h00DEADBE,  1'b0, 1'b1);
    op32("w32.rd252", 16'h00FC, 32'h0,        4'b0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/byte_lane_data_memory.md
Name: byte_lane_data_memory

Overview:
Parametrised byte-addressed data memory for the CPU datapath, the next generation of the 16-bit data memory. Generalises word width and depth, and adds per-byte write enables, registered reads with a valid strobe, and address range checking. Adds a reset-time clear sequencer so contents are deterministic after reset. Sits between the ALU address path and the register write-back mux.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8; NB = DATA_W/8 byte lanes
ADDR_W, 16, byte-address width
DEPTH_BYTES, 128, storage size in bytes; valid addresses 0..DEPTH_BYTES-1
CLEAR_ON_RESET, 1, 1 = zero all bytes after reset via the sequencer; 0 = contents untouched by reset

Ports:
Clock  input  1  single clock, all state on posedge
ResetN  input  1  asynchronous, active-low reset
Address  input  ADDR_W  byte address of the word's first (most significant) byte
WriteData  input  DATA_W  write word, big-endian
ByteEnable  input  NB  per-lane write enable; bit NB-1 = byte at Address (MSB lane)
MemWrite  input  1  write request, sampled at posedge
MemRead  input  1  read request, sampled at posedge
ReadData  output  DATA_W  registered read word
ReadValid  output  1  one-cycle pulse: ReadData updated this cycle
Ready  output  1  memory accepts requests
AddrError  output  1  one-cycle pulse: previous request out of range

Behaviour:
- Reset (ResetN low, async): ReadData=0, ReadValid=0, AddrError=0, clear counter=0. Ready=0 if CLEAR_ON_RESET=1, else Ready=1.
- Storage byte order is big-endian. Lane k (k=0 is MSB) maps WriteData[DATA_W-1-8k -: 8] to byte Address+k.
- FSM, two states:
  - CLEAR: writes 0 to byte[cnt] and increments cnt each cycle. After the cycle that writes byte DEPTH_BYTES-1, go to RUN. CLEAR lasts exactly DEPTH_BYTES cycles after ResetN deasserts.
  - RUN: Ready=1.
  - With CLEAR_ON_RESET=0, reset enters RUN directly.
- While Ready=0, MemRead and MemWrite are ignored: no write, no ReadValid, no AddrError.
- Range check: a request is in range iff Address+NB-1 < DEPTH_BYTES. The sum is computed at ADDR_W+1 bits, so there is no wrap. Unaligned addresses are legal.
- Write (RUN, MemWrite=1, in range): at the posedge, each lane with ByteEnable set is written. Lanes with ByteEnable clear are unchanged.
- Read (RUN, MemRead=1, in range): latency 1.
  - At the sampling posedge, ReadData is loaded with bytes Address..Address+NB-1 and ReadValid=1 for that cycle.
  - ReadData holds its value until the next valid read.
- Out-of-range request (read, write, or both): AddrError=1 for the cycle after the sampling edge.
  - A write is fully suppressed; no partial lanes are written.
  - A read loads ReadData=0 and still pulses ReadValid=1.
- Simultaneous MemRead and MemWrite: the read returns the pre-write contents (read-before-write). The write commits at the same edge.
- Back-to-back: a read in the cycle after a write to the same bytes returns the new data.
- Reset asserted mid-CLEAR or mid-RUN: immediate return to reset values. CLEAR restarts from byte 0. An in-flight ReadValid is dropped.

Decomposition:
- Package dm_pkg holds:
  - BYTE_W=8
  - the state enum {DM_CLEAR, DM_RUN}
  - a helper function for the lane-to-bit-slice mapping
- Sub-module dm_clear_seq: clear counter, done flag, and zero-write address/enable. It is instantiated only when CLEAR_ON_RESET=1.
- The top level owns the storage array, lane write logic, range check, and read register.

Test Plan:
1. Defaults, release ResetN at t0 → Ready=0 for 128 cycles, then 1. Read Address=0 → next cycle ReadData=0x0000, ReadValid=1.
2. Write Address=2, WriteData=0x1234, ByteEnable=2'b11, then read Address=2 → ReadData=0x1234. Read Address=3 → ReadData=0x3400 (byte 4 cleared).
3. Then write Address=2, WriteData=0xABCD, ByteEnable=2'b01 → read Address=2 gives 0x12CD. ByteEnable=2'b10 with 0xEF00 → read gives 0xEFCD.
4. Same cycle MemRead=1, MemWrite=1, Address=2, WriteData=0x5678, ByteEnable=2'b11 → ReadData=0xEFCD with ReadValid=1. A following read returns 0x5678.
5. Write Address=127 → AddrError pulses 1 cycle and byte 127 is unchanged (reads via Address=126 as before). Read Address=0xFFFF → AddrError=1, ReadValid=1, ReadData=0. Address=126 is accepted without error.
6. Pull ResetN low at CLEAR cycle 50, release → Ready low for a further 128 cycles. Previously written bytes read 0. Parameter sweep DATA_W=32, DEPTH_BYTES=256: write 0xDEADBEEF at Address=4 → byte 4=0xDE, byte 7=0xEF.
